// File: rtl/router_fsm.sv
// Packet-control FSM for the 1x3 router: decodes the header address, sequences
// header/payload/parity loads and stalls the source on FIFO full or not-empty.
module router_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       sel_empty, sel_soft, live_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid)
            addr_d = data_in;
    end

    always_comb begin
        sel_empty = 1'b0;
        sel_soft  = 1'b0;
        case (addr_q)
            2'd0:    begin sel_empty = fifo_empty_0; sel_soft = soft_reset_0; end
            2'd1:    begin sel_empty = fifo_empty_1; sel_soft = soft_reset_1; end
            2'd2:    begin sel_empty = fifo_empty_2; sel_soft = soft_reset_2; end
            default: begin sel_empty = 1'b0;         sel_soft = 1'b0;         end
        endcase
    end

    // Header decode looks at the live address, since addr_q is only captured on this edge.
    always_comb begin
        live_empty = 1'b0;
        case (data_in)
            2'd0:    live_empty = fifo_empty_0;
            2'd1:    live_empty = fifo_empty_1;
            2'd2:    live_empty = fifo_empty_2;
            default: live_empty = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q != DECODE_ADDRESS && sel_soft) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS:
                    if (pkt_valid && data_in != 2'd3)
                        state_d = live_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                WAIT_TILL_EMPTY:
                    if (sel_empty) state_d = LOAD_FIRST_DATA;
                LOAD_FIRST_DATA:
                    state_d = LOAD_DATA;
                LOAD_DATA:
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                FIFO_FULL_STATE:
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                LOAD_PARITY:
                    state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:
                    state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        full_state    = (state_q == FIFO_FULL_STATE);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                     || (state_q == LOAD_AFTER_FULL);
        busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; each state is identified by its full output vector
// {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy}.
module tb_router_fsm;

    localparam logic [7:0] S_DA   = 8'b1000_0000;
    localparam logic [7:0] S_LFD  = 8'b0100_0001;
    localparam logic [7:0] S_LD   = 8'b0010_0010;
    localparam logic [7:0] S_LAF  = 8'b0001_0011;
    localparam logic [7:0] S_FULL = 8'b0000_1001;
    localparam logic [7:0] S_LP   = 8'b0000_0011;
    localparam logic [7:0] S_CPE  = 8'b0000_0101;
    localparam logic [7:0] S_WTE  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [7:0] outs;
    int         compared = 0;
    int         mismatched = 0;

    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy};

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b1; data_in = 2'd1; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        step(); step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL reset_outs: got %b want %b", outs, S_DA); end
        compared++; if (dut.addr_q !== 2'd0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", dut.addr_q); end
        resetn = 1'b1; pkt_valid = 1'b0;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL idle_da: got %b want %b", outs, S_DA); end
    endtask

    task automatic test_packet();
        pkt_valid = 1'b1; data_in = 2'd1;
        step();
        compared++; if (outs !== S_LFD) begin mismatched++; $display("FAIL pkt_lfd: got %b want %b", outs, S_LFD); end
        compared++; if (dut.addr_q !== 2'd1) begin mismatched++; $display("FAIL pkt_addr: got %0d want 1", dut.addr_q); end
        data_in = 2'd0;
        step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL pkt_ld1: got %b want %b", outs, S_LD); end
        step(); step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL pkt_ld3: got %b want %b", outs, S_LD); end
        pkt_valid = 1'b0;
        step();
        compared++; if (outs !== S_LP) begin mismatched++; $display("FAIL pkt_lp: got %b want %b", outs, S_LP); end
        step();
        compared++; if (outs !== S_CPE) begin mismatched++; $display("FAIL pkt_cpe: got %b want %b", outs, S_CPE); end
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL pkt_da: got %b want %b", outs, S_DA); end
    endtask

    task automatic test_wait_and_full();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        step();
        compared++; if (outs !== S_WTE) begin mismatched++; $display("FAIL wte_1: got %b want %b", outs, S_WTE); end
        data_in = 2'd0;  // live address must no longer matter
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (outs !== S_WTE) begin mismatched++; $display("FAIL wte_hold%0d: got %b want %b", i, outs, S_WTE); end
        end
        fifo_empty_2 = 1'b1;
        step();
        compared++; if (outs !== S_LFD) begin mismatched++; $display("FAIL wte_lfd: got %b want %b", outs, S_LFD); end
        step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL wte_ld: got %b want %b", outs, S_LD); end
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (outs !== S_FULL) begin mismatched++; $display("FAIL full_hold%0d: got %b want %b", i, outs, S_FULL); end
        end
        fifo_full = 1'b0;
        step();
        compared++; if (outs !== S_LAF) begin mismatched++; $display("FAIL laf_1: got %b want %b", outs, S_LAF); end
        step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL laf_to_ld: got %b want %b", outs, S_LD); end
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        step();
        compared++; if (outs !== S_LAF) begin mismatched++; $display("FAIL laf_2: got %b want %b", outs, S_LAF); end
        parity_done = 1'b1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL laf_to_da: got %b want %b", outs, S_DA); end
        parity_done = 1'b0; pkt_valid = 1'b0;
    endtask

    task automatic test_low_pkt_valid();
        pkt_valid = 1'b1; data_in = 2'd1;
        step(); step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL low_ld: got %b want %b", outs, S_LD); end
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0; pkt_valid = 1'b0;
        step();
        compared++; if (outs !== S_LAF) begin mismatched++; $display("FAIL low_laf: got %b want %b", outs, S_LAF); end
        low_pkt_valid = 1'b1;
        step();
        compared++; if (outs !== S_LP) begin mismatched++; $display("FAIL laf_to_lp: got %b want %b", outs, S_LP); end
        low_pkt_valid = 1'b0;
        step();
        compared++; if (outs !== S_CPE) begin mismatched++; $display("FAIL low_cpe: got %b want %b", outs, S_CPE); end
        fifo_full = 1'b1;
        step();
        compared++; if (outs !== S_FULL) begin mismatched++; $display("FAIL cpe_to_full: got %b want %b", outs, S_FULL); end
        fifo_full = 1'b0;
        step();
        parity_done = 1'b1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL low_da: got %b want %b", outs, S_DA); end
        parity_done = 1'b0;
    endtask

    task automatic test_full_priority();
        pkt_valid = 1'b1; data_in = 2'd0;
        step(); step();
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step();
        compared++; if (outs !== S_FULL) begin mismatched++; $display("FAIL full_over_parity: got %b want %b", outs, S_FULL); end
        fifo_full = 1'b0;
        step();
        parity_done = 1'b1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL prio_da: got %b want %b", outs, S_DA); end
        parity_done = 1'b0;
    endtask

    task automatic test_soft_reset();
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
        step();
        compared++; if (outs !== S_WTE) begin mismatched++; $display("FAIL sr_wte: got %b want %b", outs, S_WTE); end
        pkt_valid = 1'b0; soft_reset_2 = 1'b1;
        step();
        compared++; if (outs !== S_WTE) begin mismatched++; $display("FAIL sr_other_port: got %b want %b", outs, S_WTE); end
        soft_reset_2 = 1'b0; soft_reset_0 = 1'b1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL sr_sel_port: got %b want %b", outs, S_DA); end
        fifo_empty_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
        step();
        compared++; if (outs !== S_LFD) begin mismatched++; $display("FAIL sr_ignored_da: got %b want %b", outs, S_LFD); end
        step();
        compared++; if (outs !== S_LD) begin mismatched++; $display("FAIL sr_stale_port: got %b want %b", outs, S_LD); end
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL sr_in_ld: got %b want %b", outs, S_DA); end
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
    endtask

    task automatic test_addr3();
        pkt_valid = 1'b1; data_in = 2'd3;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL addr3_a: got %b want %b", outs, S_DA); end
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL addr3_b: got %b want %b", outs, S_DA); end
        pkt_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        pkt_valid = 1'b1; data_in = 2'd2;
        step(); step();
        pkt_valid = 1'b0;
        step(); step();
        compared++; if (outs !== S_CPE) begin mismatched++; $display("FAIL b2b_cpe: got %b want %b", outs, S_CPE); end
        pkt_valid = 1'b1; data_in = 2'd1;
        step();
        compared++; if (outs !== S_DA) begin mismatched++; $display("FAIL b2b_da: got %b want %b", outs, S_DA); end
        step();
        compared++; if (outs !== S_LFD) begin mismatched++; $display("FAIL b2b_lfd: got %b want %b", outs, S_LFD); end
        pkt_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_wait_and_full();
        test_low_pkt_valid();
        test_full_priority();
        test_soft_reset();
        test_addr3();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-control state machine for the 1x3 router.
- Decodes the 2-bit destination address in each header byte and sequences the header, payload and parity loads into the register stage.
- Stalls the source on destination-FIFO full or not-empty, and recovers on per-port soft reset.
- Drives every control strobe the register stage consumes; consumes its parity_done and low_pkt_valid.

Parameters:
- None. Port count is fixed at 3; the address field is data_in[1:0].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source byte valid; high for header and payload, low on the parity byte.
- data_in  in  2  address bits [1:0] of the source byte. 0/1/2 are valid ports; 3 is invalid.
- fifo_full  in  1  full flag of the currently selected destination FIFO.
- fifo_empty_0/1/2  in  1 each  empty flag of FIFO 0/1/2.
- soft_reset_0/1/2  in  1 each  timeout soft reset of output port 0/1/2.
- parity_done  in  1  from the register stage: parity byte captured.
- low_pkt_valid  in  1  from the register stage: pkt_valid fell during the load.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable: high in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- busy  out  1  stall to source: high in every state except DECODE_ADDRESS and LOAD_DATA.

Behaviour:
- One-hot or binary encoding is allowed. All outputs are Moore: a pure decode of the current state, with no combinational path from any input.
- Reset (resetn=0 at a clk edge):
  - state = DECODE_ADDRESS and addr_q = 0.
  - Outputs: detect_add=1; all other outputs 0, including busy=0.
- addr_q capture: loaded from data_in when state=DECODE_ADDRESS and pkt_valid=1; held otherwise. sel_empty = fifo_empty_[addr_q]; sel_soft = soft_reset_[addr_q].
- Next-state priority: resetn, then soft reset, then normal transitions.
- Soft reset: if sel_soft=1 in any state other than DECODE_ADDRESS, next state = DECODE_ADDRESS. This overrides all other transitions.
- DECODE_ADDRESS (address decode uses the live data_in and fifo_empty_[data_in], not addr_q):
  - pkt_valid=1, data_in<3, fifo_empty_[data_in]=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in<3, fifo_empty_[data_in]=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay. Address 3 never leaves DECODE_ADDRESS.
- WAIT_TILL_EMPTY: sel_empty=1 -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly 1 cycle).
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE. Full has priority over pkt_valid=0 in the same cycle.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_pkt_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Latency:
  - Header accepted to lfd_state: 1 cycle when the FIFO is empty.
  - Last payload (pkt_valid falls) to rst_int_reg: 2 cycles with no full.
  - Back-to-back packets: the next header is decoded the cycle after CHECK_PARITY_ERROR.
- Illegal or unused encodings -> DECODE_ADDRESS on the next edge.
- Soft reset of a non-selected port has no effect. All soft resets are ignored while in DECODE_ADDRESS.

Test Plan:
- Reset, then header 0x01 with pkt_valid=1 and fifo_empty_1=1 -> DECODE_ADDRESS -> LOAD_FIRST_DATA -> LOAD_DATA. busy: 0 -> 1 -> 0. lfd_state high exactly 1 cycle. addr_q=1.
- 3 payload bytes, then pkt_valid=0 with parity -> LOAD_PARITY (write_enb_reg=1, busy=1) -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS (detect_add=1).
- Header 0x02 with fifo_empty_2=0 for 4 cycles, then 1 -> WAIT_TILL_EMPTY held 4 cycles with busy=1, then LOAD_FIRST_DATA.
- In LOAD_DATA, fifo_full=1 for 3 cycles -> FIFO_FULL_STATE ×3 (full_state=1, busy=1) -> LOAD_AFTER_FULL:
  - parity_done=0, low_pkt_valid=0 -> LOAD_DATA.
  - Repeat with low_pkt_valid=1 -> LOAD_PARITY.
  - Repeat with parity_done=1 -> DECODE_ADDRESS.
- Simultaneous fifo_full=1 and pkt_valid=0 in LOAD_DATA -> FIFO_FULL_STATE, not LOAD_PARITY.
- Soft reset:
  - soft_reset_0 pulsed in WAIT_TILL_EMPTY for addr 0 -> DECODE_ADDRESS next cycle.
  - soft_reset_2 asserted while addr_q=0 -> no state change.
  - Header 0x03 with pkt_valid=1 -> stays in DECODE_ADDRESS, busy=0.
